mem_io_responder: RTL and testbench

- Byte-wide memory/IO slave on the far side of the core's load/store port (mem_a, mem_dout, mem_wr, mem_din).
- Serves a RAM array with 1-cycle registered read latency.
- Maps the IO address onto a TX byte FIFO drained by a serial/host transmitter, and drives io_buffer_full so the load/store unit can hold off IO accesses.
- Optionally serves IO reads from an RX FIFO.

---
 rtl/mem_io_responder.sv | 136 +++++++++++++
 tb/tb_mem_io_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Byte-wide RAM + IO responder for the core load/store port.
// Define IO_RX_EN to serve IO reads from an 8-deep RX FIFO.
module mem_io_responder #(
    parameter int          ADDR_WIDTH = 17,
    parameter logic [31:0] IO_ADDR    = 32'h30000,
    parameter int          FIFO_WIDTH = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data
);

    localparam int FIFO_DEPTH = 1 << FIFO_WIDTH;
    localparam logic [FIFO_WIDTH:0] DEPTH = {1'b1, {FIFO_WIDTH{1'b0}}};
    localparam logic [FIFO_WIDTH:0] NEAR_FULL = DEPTH - (FIFO_WIDTH + 1)'(2);

    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  is_io;
    logic                  ram_wr;
    logic                  io_wr;
    logic                  io_rd;
    logic [7:0]            io_rd_data;

    assign ram_addr = mem_a[ADDR_WIDTH-1:0];
    assign is_io    = (mem_a == IO_ADDR);
    assign ram_wr   = rdy_in & ~rst_in & mem_wr & ~is_io;
    assign io_wr    = rdy_in & mem_wr & is_io;
    assign io_rd    = rdy_in & ~mem_wr & is_io;

    // TX FIFO
    logic [7:0]            tx_mem [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] tx_wr_ptr;
    logic [FIFO_WIDTH-1:0] tx_rd_ptr;
    logic [FIFO_WIDTH:0]   tx_cnt;
    logic [FIFO_WIDTH:0]   tx_cnt_next;
    logic                  tx_push;
    logic                  tx_pop;

    assign tx_valid = (tx_cnt != '0);
    assign tx_data  = tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;
    assign tx_pop   = rdy_in & tx_valid & tx_ready;
    // A pop in the same edge frees a slot, so a full FIFO still accepts.
    assign tx_push  = io_wr & ((tx_cnt != DEPTH) | tx_pop);

    always_comb begin
        tx_cnt_next = tx_cnt;
        if (tx_push && !tx_pop)
            tx_cnt_next = tx_cnt + 1'b1;
        else if (tx_pop && !tx_push)
            tx_cnt_next = tx_cnt - 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wr_ptr      <= '0;
            tx_rd_ptr      <= '0;
            tx_cnt         <= '0;
            io_buffer_full <= 1'b0;
        end else if (rdy_in) begin
            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_cnt         <= tx_cnt_next;
            io_buffer_full <= (tx_cnt_next >= NEAR_FULL);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && tx_push)
            tx_mem[tx_wr_ptr] <= mem_dout;
    end

`ifdef IO_RX_EN
    logic [7:0]            rx_mem [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] rx_wr_ptr;
    logic [FIFO_WIDTH-1:0] rx_rd_ptr;
    logic [FIFO_WIDTH:0]   rx_cnt;
    logic                  rx_push;
    logic                  rx_pop;

    assign rx_push    = rdy_in & rx_valid & (rx_cnt != DEPTH);
    assign rx_pop     = io_rd & (rx_cnt != '0);
    assign io_rd_data = rx_pop ? rx_mem[rx_rd_ptr] : 8'h00;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else if (rdy_in) begin
            if (rx_push)
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_push && !rx_pop)
                rx_cnt <= rx_cnt + 1'b1;
            else if (rx_pop && !rx_push)
                rx_cnt <= rx_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rx_push)
            rx_mem[rx_wr_ptr] <= rx_data;
    end
`else
    logic unused_rx;
    assign unused_rx  = ^{rx_valid, rx_data, io_rd};
    assign io_rd_data = 8'h00;
`endif

    always_ff @(posedge clk_in) begin
        if (ram_wr)
            ram[ram_addr] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            mem_din <= 8'h00;
        else if (rdy_in && !mem_wr)
            mem_din <= is_io ? io_rd_data : ram[ram_addr];
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Random + directed bench for mem_io_responder against a queue-based model.
module tb_mem_io_responder;

    localparam logic [31:0] IO = 32'h30000;

    logic        clk_in = 0;
    logic        rst_in = 1;
    logic        rdy_in = 1;
    logic [31:0] mem_a = 0;
    logic [7:0]  mem_dout = 0;
    logic        mem_wr = 0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 0;
    logic        rx_valid = 0;
    logic [7:0]  rx_data = 0;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    logic [7:0] ram_m [logic [16:0]];
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic [7:0] m_din = 0;
    logic       m_full = 0;
    logic       cur_rdy = 1;
    logic       cur_txr = 0;
    logic [31:0] pool [16];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rdy,
                        input logic [31:0] a, input logic [7:0] d,
                        input logic wr, input logic txr,
                        input logic rxv, input logic [7:0] rxd);
        logic rx_was_full;
        logic [16:0] la;
        rst_in = rst; rdy_in = rdy; mem_a = a; mem_dout = d;
        mem_wr = wr; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        @(posedge clk_in);
        #1;
        la = a[16:0];
        if (rst) begin
            m_din = 0; m_full = 0;
            txq.delete(); rxq.delete();
        end else if (rdy) begin
            rx_was_full = (rxq.size() == 8);
            if (!wr) begin
                if (a == IO) begin
`ifdef IO_RX_EN
                    if (rxq.size() != 0) m_din = rxq.pop_front();
                    else m_din = 0;
`else
                    m_din = 0;
`endif
                end else begin
                    m_din = ram_m[la];
                end
            end
            if (wr && a != IO) ram_m[la] = d;
            if (txr && txq.size() != 0) void'(txq.pop_front());
            if (wr && a == IO && txq.size() < 8) txq.push_back(d);
`ifdef IO_RX_EN
            if (rxv && !rx_was_full) rxq.push_back(rxd);
`endif
            m_full = (txq.size() >= 6);
        end
        check("mem_din", mem_din, m_din);
        check("io_full", io_buffer_full, m_full);
        check("tx_valid", tx_valid, txq.size() != 0);
        check("tx_data", tx_data, txq.size() != 0 ? txq[0] : 8'h00);
    endtask

    task automatic bus(input logic [31:0] a, input logic [7:0] d,
                       input logic wr);
        step(1'b0, cur_rdy, a, d, wr, cur_txr, 1'b0, 8'h00);
    endtask

    logic [7:0] exp_b;

    initial begin
        // reset
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_din", mem_din, 0);
        check("rst_full", io_buffer_full, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_txd", tx_data, 0);

        // basic write / read latency
        bus(32'h10, 8'hA5, 1);
        check("din_before_read", mem_din, 0);
        bus(32'h10, 0, 0);
        check("read_a5", mem_din, 8'hA5);

        // back-to-back reads
        for (int i = 0; i < 4; i++) bus(32'h100 + i, 8'h11 * (i + 1), 1);
        for (int i = 0; i < 4; i++) begin
            bus(32'h100 + i, 0, 0);
            exp_b = 8'h11 * (i + 1);
            check("b2b_read", mem_din, exp_b);
        end

        // aliasing
        bus(32'h20100, 8'h77, 1);
        bus(32'h100, 0, 0);
        check("alias", mem_din, 8'h77);

        // TX fill with consumer stalled
        cur_txr = 0;
        for (int i = 0; i < 8; i++) begin
            bus(IO, 8'h41 + i, 1);
            if (i == 4) check("full_after5", io_buffer_full, 0);
            if (i == 5) check("full_after6", io_buffer_full, 1);
        end
        check("txv_full", tx_valid, 1);
        check("txd_head", tx_data, 8'h41);
        bus(IO, 8'h49, 1);
        check("drop_head", tx_data, 8'h41);

        // drain
        cur_txr = 1;
        for (int i = 0; i < 8; i++) begin
            exp_b = 8'h41 + i;
            check("drain", tx_data, exp_b);
            bus(32'h10, 0, 0);
        end
        check("drained_txv", tx_valid, 0);
        check("drained_full", io_buffer_full, 0);

        // push and pop together while full
        cur_txr = 0;
        for (int i = 0; i < 8; i++) bus(IO, 8'h61 + i, 1);
        cur_txr = 1;
        bus(IO, 8'h5A, 1);
        check("pp_full", io_buffer_full, 1);
        for (int i = 0; i < 8; i++) begin
            exp_b = (i < 7) ? 8'h62 + i : 8'h5A;
            check("pp_order", tx_data, exp_b);
            bus(32'h10, 0, 0);
        end
        check("pp_empty", tx_valid, 0);

        // freeze with rdy_in low, then reset mid-drain
        cur_txr = 0;
        for (int i = 0; i < 7; i++) bus(IO, 8'h71 + i, 1);
        bus(32'h10, 0, 0);
        cur_rdy = 0; cur_txr = 1;
        for (int i = 0; i < 3; i++) bus(IO, 8'h99, 1);
        check("frz_din", mem_din, 8'hA5);
        check("frz_head", tx_data, 8'h71);
        check("frz_full", io_buffer_full, 1);
        cur_rdy = 1;
        bus(32'h100, 0, 0);
        check("drain_head", tx_data, 8'h72);
        step(1, 1, 0, 0, 0, 1, 0, 0);
        check("mid_rst_txv", tx_valid, 0);
        check("mid_rst_full", io_buffer_full, 0);
        bus(32'h10, 0, 0);
        check("ram_survives", mem_din, 8'hA5);

`ifdef IO_RX_EN
        step(0, 1, 32'h10, 0, 0, 0, 1, 8'h31);
        step(0, 1, 32'h10, 0, 0, 0, 1, 8'h32);
        bus(IO, 0, 0);
        check("rx0", mem_din, 8'h31);
        bus(IO, 0, 0);
        check("rx1", mem_din, 8'h32);
        bus(IO, 0, 0);
        check("rx_empty", mem_din, 8'h00);
`else
        bus(32'h10, 0, 0);
        bus(IO, 0, 0);
        check("io_read_zero", mem_din, 8'h00);
`endif

        // randomized traffic
        for (int i = 0; i < 16; i++) begin
            pool[i] = $urandom_range(0, 32'h0FFFF);
            bus(pool[i], 8'($urandom()), 1);
        end
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic        wr;
            logic        rst;
            logic        rdy;
            int          sel;
            sel = $urandom_range(0, 2);
            a = (sel == 0) ? IO :
                (($urandom() & 32'hFFFE0000) | pool[$urandom_range(0, 15)]);
            wr  = $urandom_range(0, 1) == 1;
            rst = $urandom_range(0, 99) == 0;
            rdy = $urandom_range(0, 9) != 0;
            step(rst, rdy, a, 8'($urandom()), wr,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 8'($urandom()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
